// File: rtl/pixel_flow_if.sv
// Pixel stream bundle: upstream pixel handshake, downstream pixel handshake and status.
// The slave modport is the buffering block's view; master is the surrounding system's view.
interface pixel_flow_if #(
  parameter int X_W   = 11,
  parameter int Y_W   = 12,
  parameter int CH    = 3,
  parameter int CH_W  = 8,
  parameter int DEPTH = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [X_W-1:0]       x_in;
  logic signed [Y_W-1:0]       y_in;
  logic [CH*CH_W-1:0]          pix_in;
  logic                        clip_en;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [X_W-1:0]       x_out;
  logic signed [Y_W-1:0]       y_out;
  logic [CH*CH_W-1:0]          pix_out;
  logic                        frame_done;
  logic [15:0]                 drop_count;
  logic [$clog2(DEPTH):0]      level;

  modport slave (
    input  in_valid, x_in, y_in, pix_in, clip_en, out_ready,
    output in_ready, out_valid, x_out, y_out, pix_out, frame_done, drop_count, level
  );

  modport master (
    output in_valid, x_in, y_in, pix_in, clip_en, out_ready,
    input  in_ready, out_valid, x_out, y_out, pix_out, frame_done, drop_count, level
  );
endinterface

// File: rtl/pixel_flow.sv
// First-word fall-through pixel buffer with optional off-screen clipping,
// a saturating drop counter and an end-of-frame pulse on the last pixel popped.
module pixel_flow #(
  parameter int X_W   = 11,
  parameter int Y_W   = 12,
  parameter int CH    = 3,
  parameter int CH_W  = 8,
  parameter int DEPTH = 4,
  parameter int X_MAX = 31,
  parameter int Y_MAX = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  pixel_flow_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = CH * CH_W;
  localparam logic [LW-1:0]        FULL  = LW'(DEPTH);
  localparam logic signed [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic signed [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  typedef struct packed {
    logic signed [X_W-1:0] x;
    logic signed [Y_W-1:0] y;
    logic [CW-1:0]         pix;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     drop_q, drop_d;
  logic            frame_q, frame_d;
  logic            in_hs, out_hs, off_screen, push;

  // Sign bit catches negative coordinates; the upper bound compare is signed.
  assign off_screen = bus.x_in[X_W-1] || (bus.x_in > X_LIM) ||
                      bus.y_in[Y_W-1] || (bus.y_in > Y_LIM);
  assign head       = mem[rd_q];

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    in_hs   = bus.in_valid && (level_q < FULL);
    out_hs  = (level_q != '0) && bus.out_ready;
    push    = in_hs && !(bus.clip_en && off_screen);
    wr_d    = push   ? wr_q + PW'(1) : wr_q;
    rd_d    = out_hs ? rd_q + PW'(1) : rd_q;
    drop_d  = drop_q;
    level_d = level_q;
    frame_d = out_hs && (head.x == X_LIM) && (head.y == Y_LIM);
    if (in_hs && bus.clip_en && off_screen && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
    unique case ({push, out_hs})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      drop_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      drop_q  <= drop_d;
      frame_q <= frame_d;
    end
  end

  // NOTE: storage is deliberately not reset; outputs are masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_q] <= '{x: bus.x_in, y: bus.y_in, pix: bus.pix_in};
  end

  assign bus.in_ready   = (level_q < FULL);
  assign bus.out_valid  = (level_q != '0);
  assign bus.x_out      = bus.out_valid ? head.x   : '0;
  assign bus.y_out      = bus.out_valid ? head.y   : '0;
  assign bus.pix_out    = bus.out_valid ? head.pix : '0;
  assign bus.frame_done = frame_q;
  assign bus.drop_count = drop_q;
  assign bus.level      = level_q;
endmodule

// File: tb/tb_pixel_flow.sv
// Directed bench for pixel_flow: a queue-based model of the buffer is compared
// against the DUT on every falling edge, plus literal expectations per scenario.
module tb_pixel_flow;
  localparam int X_W = 11, Y_W = 12, CH = 3, CH_W = 8, DEPTH = 4;
  localparam int X_MAX = 31, Y_MAX = 31;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pixel_flow_if #(.X_W(X_W), .Y_W(Y_W), .CH(CH), .CH_W(CH_W), .DEPTH(DEPTH)) bus();

  pixel_flow #(.X_W(X_W), .Y_W(Y_W), .CH(CH), .CH_W(CH_W), .DEPTH(DEPTH),
               .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          x;
    int          y;
    logic [23:0] pix;
  } ent_t;

  ent_t q[$];
  int   m_drops;
  bit   m_frame;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   out_cnt = 0;
  int   fr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of stored pixels plus a saturating drop tally.
  always @(posedge clk) begin
    bit acc, pop, oob;
    int xs, ys;
    if (!rst_n) begin
      q.delete();
      m_drops = 0;
      m_frame = 1'b0;
    end else begin
      acc = bus.in_valid && (q.size() < DEPTH);
      pop = (q.size() != 0) && bus.out_ready;
      m_frame = pop && (q[0].x == X_MAX) && (q[0].y == Y_MAX);
      if (pop) void'(q.pop_front());
      if (acc) begin
        xs  = int'(bus.x_in);
        ys  = int'(bus.y_in);
        oob = (xs < 0) || (xs > X_MAX) || (ys < 0) || (ys > Y_MAX);
        if (bus.clip_en && oob) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          q.push_back('{x: xs, y: ys, pix: bus.pix_in});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",   bus.in_ready,   q.size() < DEPTH);
      check("out_valid",  bus.out_valid,  q.size() != 0);
      check("level",      bus.level,      q.size());
      check("drop_count", bus.drop_count, m_drops);
      check("frame_done", bus.frame_done, m_frame);
      check("x_out",   bus.x_out,   (q.size() != 0) ? q[0].x   : 0);
      check("y_out",   bus.y_out,   (q.size() != 0) ? q[0].y   : 0);
      check("pix_out", bus.pix_out, (q.size() != 0) ? q[0].pix : 24'h0);
      if (bus.out_valid && bus.out_ready) out_cnt++;
      if (bus.frame_done) fr_cnt++;
    end
  end

  function automatic logic [23:0] pix_of(input int x, input int y);
    return {8'(x) ^ 8'h5A, 8'(y), 8'(x + y)};
  endfunction

  // Holds the pixel on the bus until it is accepted; leaves in_valid high afterwards.
  task automatic send(input int x, input int y, input logic [23:0] p, input bit clip);
    bus.in_valid = 1'b1;
    bus.x_in     = X_W'(x);
    bus.y_in     = Y_W'(y);
    bus.pix_in   = p;
    bus.clip_en  = clip;
    @(negedge clk);
    for (int t = 0; t < 64 && !bus.in_ready; t++) @(negedge clk);
    check("in_accept", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_out, base_fr;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.pix_in    = '0;
    bus.clip_en   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_level",     bus.level,     0);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_x_out",     bus.x_out,     0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full raster with no backpressure.
    bus.out_ready = 1'b1;
    base_out = out_cnt;
    base_fr  = fr_cnt;
    for (int y = 0; y <= Y_MAX; y++)
      for (int x = 0; x <= X_MAX; x++)
        send(x, y, pix_of(x, y), 1'b0);
    idle_cycles(4);
    check("raster_outputs", out_cnt - base_out, 1024);
    check("raster_frames",  fr_cnt - base_fr,   1);
    check("raster_drops",   bus.drop_count,     0);

    // Backpressure: four fill the buffer, the fifth stalls.
    bus.out_ready = 1'b0;
    base_out = out_cnt;
    for (int i = 0; i < 4; i++) send(100 + i, 3, pix_of(i, 7), 1'b0);
    bus.x_in   = X_W'(104);
    bus.pix_in = pix_of(4, 7);
    repeat (3) @(negedge clk);
    check("bp_level",    bus.level,    4);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_head_x",   bus.x_out,    100);
    bus.out_ready = 1'b1;
    send(104, 3, pix_of(4, 7), 1'b0);
    send(105, 3, pix_of(5, 7), 1'b0);
    idle_cycles(8);
    check("bp_outputs", out_cnt - base_out, 6);

    // Clipping of each out-of-screen edge case.
    base_out = out_cnt;
    send(-1, 5,  24'h111111, 1'b1);
    send(32, 0,  24'h222222, 1'b1);
    send(5,  32, 24'h333333, 1'b1);
    send(10, 10, 24'hABCDEF, 1'b1);
    idle_cycles(4);
    check("clip_drops",   bus.drop_count,     3);
    check("clip_outputs", out_cnt - base_out, 1);

    // Steady push+pop at level 2, pointers wrap several times.
    bus.out_ready = 1'b0;
    send(1, 1, 24'h000101, 1'b0);
    send(2, 2, 24'h000202, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(20 + i, 30 - i, pix_of(20 + i, i), 1'b0);
    @(negedge clk);
    check("pp_level", bus.level, 2);
    idle_cycles(4);

    // Saturating drop counter.
    for (int i = 0; i < 65537; i++) send(-1, i % 30, 24'h0, 1'b1);
    idle_cycles(2);
    check("sat_drops", bus.drop_count, 16'hFFFF);

    // Reset in the middle of a stream.
    bus.out_ready = 1'b0;
    send(3, 4, 24'h010203, 1'b0);
    send(5, 6, 24'h040506, 1'b0);
    send(7, 8, 24'h070809, 1'b0);
    idle_cycles(1);
    @(negedge clk);
    check("mr_level_pre", bus.level, 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_level",     bus.level,      0);
    check("mr_out_valid", bus.out_valid,  0);
    check("mr_drops",     bus.drop_count, 0);
    check("mr_x_out",     bus.x_out,      0);
    send(7, 9, 24'hC0FFEE, 1'b0);
    idle_cycles(1);
    @(negedge clk);
    check("mr_next_valid", bus.out_valid, 1);
    check("mr_next_x",     bus.x_out,     7);
    check("mr_next_y",     bus.y_out,     9);
    check("mr_next_pix",   bus.pix_out,   24'hC0FFEE);
    bus.out_ready = 1'b1;
    idle_cycles(3);
    check("mr_drained", bus.level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
